sram_burst_core: RTL
====================

SRAM_BURST_CORE -- requirements
Module: sram_burst_core

Interface
REQ-001 SHALL have parameter ROW_BITS, default 6, row address width (2^ROW_BITS rows).
REQ-002 SHALL have parameter COL_BITS, default 4, column-word address width (2^COL_BITS words per row).
REQ-003 SHALL have parameter WORD_BITS, default 4, data word width.
REQ-004 SHALL have parameter BURST_BITS, default 2, burst-length field width.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  request accepted when req_valid & req_ready at a rising edge.
REQ-009 SHALL have port req_rnw  input  1  1=read, 0=write.
REQ-010 SHALL have port req_addr  input  ROW_BITS+COL_BITS  {row, col}; row in the MSBs.
REQ-011 SHALL have port req_wdata  input  WORD_BITS  write data.
REQ-012 SHALL have port req_wmask  input  WORD_BITS  per-bit write enable, 1=write that bit.
REQ-013 SHALL have port req_burst  input  BURST_BITS  read beats minus one.
REQ-014 SHALL have port rsp_valid  output  1  read data valid; one-cycle pulse per beat, no backpressure.
REQ-015 SHALL have port rsp_data  output  WORD_BITS  read data; all-zero whenever rsp_valid=0.
REQ-016 SHALL have port wordline  output  2^ROW_BITS  one-hot row select; all-zero outside ACCESS.
REQ-017 SHALL have port precharge_en  output  1  high only in PRECHARGE.
REQ-018 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-019 SHALL hold an internal array of 2^(ROW_BITS+COL_BITS) words of WORD_BITS bits.
REQ-020 SHALL implement FSM states IDLE, PRECHARGE, ACCESS.
REQ-021 SHALL assert req_ready only in IDLE, combinationally from state alone; IDLE->PRECHARGE on acceptance, capturing rnw, addr, wdata, wmask and burst.
REQ-022 SHALL spend exactly one cycle in PRECHARGE, then enter ACCESS.
REQ-023 In ACCESS, a write SHALL update only the masked bits of the word at the captured address at the end of the cycle, then return to IDLE; req_burst SHALL be ignored for writes.
REQ-024 In ACCESS, a read SHALL stay for req_burst+1 cycles (one beat per cycle); each beat SHALL drive rsp_valid=1 with that beat's word in the following cycle.
REQ-025 Burst column SHALL increment by 1 per beat modulo 2^COL_BITS, wrapping within the same row; the row SHALL never change within a burst.
REQ-026 After the last beat, the FSM SHALL return to IDLE; the last rsp_valid and req_ready=1 SHALL coincide in that IDLE cycle.
REQ-027 Single-beat latency SHALL be: accept at cycle N, PRECHARGE N+1, ACCESS N+2, rsp_valid N+3; next acceptance possible at N+3.
REQ-028 A read of a word written by the immediately preceding request SHALL return the newly written value.
REQ-029 wordline SHALL equal one-hot(captured row) throughout ACCESS and zero otherwise.
REQ-030 With an all-zero wmask, a write SHALL execute its full FSM sequence and leave the array unchanged.

Reset
REQ-031 While rst=1 at a rising edge, the FSM SHALL go to IDLE, and at the next cycle rsp_valid=0, rsp_data=0, wordline=0, precharge_en=0, busy=0, req_ready=1.
REQ-032 Reset in any state, including mid-burst, SHALL abort the operation; no further rsp_valid pulses from it; a pending write in ACCESS SHALL NOT commit on that edge.
REQ-033 Array contents SHALL be unaffected by rst; initial contents are undefined.

Verification
REQ-034 Write addr 0x025, wdata 0xA, wmask 0xF; read 0x025 -> rsp_valid exactly 3 cycles after read acceptance, rsp_data 0xA, wordline bit 2 high during ACCESS only.
REQ-035 Word 0x3F0 = 0x0; write 0x3F0 wdata 0xF, wmask 0x5; read -> 0x5.
REQ-036 Words 0x10E, 0x10F, 0x100, 0x101 written 1,2,3,4; read 0x10E burst 3 -> four consecutive rsp_valid beats 1,2,3,4, wordline bit 16 only, busy for 5 cycles.
REQ-037 req_valid held high across back-to-back write/read of 0x001 -> req_ready=1 only in IDLE cycles, read returns the new data, no request lost or duplicated.
REQ-038 rst pulsed during the second beat of a 4-beat read -> no further rsp_valid, all outputs at reset values next cycle, earlier-written data still readable.
REQ-039 rst asserted in ACCESS of write 0x200 wdata 0x9 over stored 0x6 -> subsequent read 0x200 returns 0x6.

Source files
------------

// File: rtl/sram_burst_core.sv
// ============================================================================
// Module : sram_burst_core
// Brief  : Single-port SRAM core with precharge/access sequencing, masked
//          writes and wrapping read bursts within a row.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_burst_core #(
    parameter int ROW_BITS   = 6,
    parameter int COL_BITS   = 4,
    parameter int WORD_BITS  = 4,
    parameter int BURST_BITS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_rnw,
    input  logic [ROW_BITS+COL_BITS-1:0] req_addr,
    input  logic [WORD_BITS-1:0]         req_wdata,
    input  logic [WORD_BITS-1:0]         req_wmask,
    input  logic [BURST_BITS-1:0]        req_burst,
    output logic                         rsp_valid,
    output logic [WORD_BITS-1:0]         rsp_data,
    output logic [(1<<ROW_BITS)-1:0]     wordline,
    output logic                         precharge_en,
    output logic                         busy
);

    localparam int ROWS  = 1 << ROW_BITS;
    localparam int WORDS = 1 << (ROW_BITS + COL_BITS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  rnw_q;
    logic [ROW_BITS-1:0]   row_q;
    logic [COL_BITS-1:0]   col_q, col_d;
    logic [WORD_BITS-1:0]  wdata_q, wmask_q;
    logic [BURST_BITS-1:0] beats_q, beats_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [WORD_BITS-1:0]  rsp_data_q, rsp_data_d;
    logic [WORD_BITS-1:0]  mem_q [WORDS];

    logic                         w_accept;
    logic                         w_commit;
    logic [ROW_BITS+COL_BITS-1:0] w_addr;
    logic [WORD_BITS-1:0]         w_word;

    assign w_addr = {row_q, col_q};
    assign w_word = mem_q[w_addr];

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        beats_d     = beats_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        w_commit    = 1'b0;
        w_accept    = req_valid && (state_q == S_IDLE);
        case (state_q)
            S_IDLE: if (w_accept) state_d = S_PRE;
            S_PRE:  state_d = S_ACC;
            S_ACC: begin
                if (rnw_q) begin
                    // Column wraps within the row; the row is never touched.
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = w_word;
                    col_d       = col_q + 1'b1;
                    if (beats_q == '0) state_d = S_IDLE;
                    else               beats_d = beats_q - 1'b1;
                end else begin
                    w_commit = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            rnw_q   <= req_rnw;
            row_q   <= req_addr[ROW_BITS+COL_BITS-1:COL_BITS];
            col_q   <= req_addr[COL_BITS-1:0];
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
            beats_q <= req_burst;
        end else begin
            col_q   <= col_d;
            beats_q <= beats_d;
        end
    end

    // Array has no reset; a write caught by reset in ACCESS is dropped.
    always_ff @(posedge clk) begin
        if (w_commit && !rst)
            mem_q[w_addr] <= (w_word & ~wmask_q) | (wdata_q & wmask_q);
    end

    assign req_ready    = (state_q == S_IDLE);
    assign precharge_en = (state_q == S_PRE);
    assign busy         = (state_q != S_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign wordline     = (state_q == S_ACC) ? ({{(ROWS-1){1'b0}}, 1'b1} << row_q) : '0;

endmodule

`default_nettype wire
